// File: rtl/pico_wb_bridge.sv
// PicoMem slave to Wishbone classic master bridge.
// One Wishbone single cycle per PicoMem transfer, with timeout and error word.
module pico_wb_bridge #(
    parameter int          ADDR_W   = 28,
    parameter int          TIMEOUT  = 256,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_s_valid,
    output logic              mem_s_ready,
    input  logic [31:0]       mem_s_addr,
    input  logic [31:0]       mem_s_wdata,
    input  logic [3:0]        mem_s_wstrb,
    output logic [31:0]       mem_s_rdata,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    output logic [3:0]        wb_sel_o,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    output logic              err_pulse,
    output logic [7:0]        err_count
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMAX = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          start;
    logic          done_ok;
    logic          done_err;

    logic unused_addr;
    assign unused_addr = ^{mem_s_addr[31:ADDR_W+2], mem_s_addr[1:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // err beats ack; ack beats the final timeout cycle
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        done_ok   = 1'b0;
        done_err  = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_s_valid && !mem_s_ready) begin
                    start     = 1'b1;
                    state_nxt = BUS;
                end
            end
            BUS: begin
                if (wb_err_i) begin
                    done_err  = 1'b1;
                    state_nxt = RESP;
                end else if (wb_ack_i) begin
                    done_ok   = 1'b1;
                    state_nxt = RESP;
                end else if (TIMEOUT != 0 && cnt == TMAX) begin
                    done_err  = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_s_ready <= 1'b0;
            mem_s_rdata <= '0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_sel_o    <= '0;
            err_pulse   <= 1'b0;
            err_count   <= '0;
            cnt         <= '0;
        end else begin
            mem_s_ready <= 1'b0;
            err_pulse   <= 1'b0;
            if (start) begin
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_we_o  <= |mem_s_wstrb;
                wb_sel_o <= (|mem_s_wstrb) ? mem_s_wstrb : 4'hF;
                wb_adr_o <= mem_s_addr[ADDR_W+1:2];
                wb_dat_o <= mem_s_wdata;
                cnt      <= '0;
            end
            if (state == BUS) begin
                cnt <= cnt + CW'(1);
            end
            if (done_ok || done_err) begin
                wb_cyc_o    <= 1'b0;
                wb_stb_o    <= 1'b0;
                mem_s_ready <= mem_s_valid;
                err_pulse   <= done_err;
                if (done_err) begin
                    mem_s_rdata <= ERR_DATA;
                end else begin
                    mem_s_rdata <= wb_we_o ? 32'h0 : wb_dat_i;
                end
                if (done_err && err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule
